// File: rtl/multiword_adder_sequencer.sv
// Wide adder that reuses one NUMBITS-wide ripple-carry slice over WORDS cycles, LSW first.
// Optional macro SUBTRACT_EN adds a 'sub' input that turns the operation into A-B.

module ripple_carry_adder #(
    parameter int unsigned NUMBITS = 16
) (
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               carryin,
    output logic [NUMBITS-1:0] sum,
    output logic               carryout
);

    logic [NUMBITS:0] w_c;

    assign w_c[0] = carryin;

    // Plain full-adder chain, no synthesis-tool adder inference.
    for (genvar i = 0; i < NUMBITS; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign carryout = w_c[NUMBITS];

endmodule

module multiword_adder_sequencer #(
    parameter int unsigned NUMBITS = 16,
    parameter int unsigned WORDS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
`ifdef SUBTRACT_EN
    input  logic                       sub,
`endif
    input  logic [NUMBITS*WORDS-1:0]   A,
    input  logic [NUMBITS*WORDS-1:0]   B,
    input  logic                       carryin,
    output logic                       busy,
    output logic                       done,
    output logic [NUMBITS*WORDS-1:0]   result,
    output logic                       carryout,
    output logic                       overflow
);

    localparam int unsigned W     = NUMBITS * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_last;
    logic                 w_accept;

    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_carry;
    logic [IDX_W-1:0]     r_idx;
    logic [NUMBITS-1:0]   r_shadow [WORDS];

    logic [NUMBITS-1:0]   w_a_words [WORDS];
    logic [NUMBITS-1:0]   w_b_words [WORDS];
    logic [NUMBITS-1:0]   w_sum;
    logic                 w_cout;
    logic [W-1:0]         w_full_sum;

    assign w_last   = (r_idx == IDX_W'(WORDS - 1));
    assign w_accept = (r_state == S_IDLE) && start;

    // Word views of the captured operands; full sum merges the word being added now.
    for (genvar k = 0; k < WORDS; k++) begin : g_words
        assign w_a_words[k] = r_a[k*NUMBITS +: NUMBITS];
        assign w_b_words[k] = r_b[k*NUMBITS +: NUMBITS];
        assign w_full_sum[k*NUMBITS +: NUMBITS] =
            (r_idx == IDX_W'(k)) ? w_sum : r_shadow[k];
    end

    ripple_carry_adder #(
        .NUMBITS (NUMBITS)
    ) u_rca (
        .a        (w_a_words[r_idx]),
        .b        (w_b_words[r_idx]),
        .carryin  (r_carry),
        .sum      (w_sum),
        .carryout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-word iteration, and publication of the finished sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_accept) begin
            r_a   <= A;
            r_idx <= '0;
`ifdef SUBTRACT_EN
            r_b     <= sub ? ~B : B;
            r_carry <= sub | carryin;
`else
            r_b     <= B;
            r_carry <= carryin;
`endif
        end else if (r_state == S_RUN) begin
            r_shadow[r_idx] <= w_sum;
            r_carry         <= w_cout;
            if (w_last) begin
                result   <= w_full_sum;
                carryout <= w_cout;
                overflow <= (r_a[W-1] == r_b[W-1]) && (w_full_sum[W-1] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed bench for multiword_adder_sequencer (NUMBITS=16, WORDS=4).
module tb_multiword_adder_sequencer;

    localparam int unsigned NUMBITS = 16;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned W       = NUMBITS * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         carryin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;

    int n_checks;
    int n_errors;
    logic [W-1:0] held_result;

    multiword_adder_sequencer #(
        .NUMBITS (NUMBITS),
        .WORDS   (WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SUBTRACT_EN
        .sub      (sub),
`endif
        .A        (a_in),
        .B        (b_in),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Start at the current negedge; checks busy/done timing, hold of old result, final values.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, input logic [W-1:0] exp_res,
                          input logic exp_co, input logic exp_ov, input bit poke_start);
        start   = 1'b1;
        a_in    = a;
        b_in    = b;
        carryin = cin;
        sub     = sb;
        @(negedge clk);
        start   = 1'b0;
        a_in    = ~a;
        b_in    = a ^ b;
        carryin = ~cin;
        sub     = ~sb;
        for (int i = 0; i < WORDS; i++) begin
            check("busy_run", W'(busy), W'(1));
            check("done_run", W'(done), W'(0));
            check("result_held", result, held_result);
            start = (poke_start && i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", W'(done), W'(1));
        check("busy_done", W'(busy), W'(0));
        check("result", result, exp_res);
        check("carryout", W'(carryout), W'(exp_co));
        check("overflow", W'(overflow), W'(exp_ov));
        held_result = exp_res;
        @(negedge clk);
        check("done_low", W'(done), W'(0));
        check("busy_idle", W'(busy), W'(0));
        check("result_stable", result, exp_res);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_done"}, W'(done), W'(0));
        check({tag, "_result"}, result, W'(0));
        check({tag, "_carryout"}, W'(carryout), W'(0));
        check({tag, "_overflow"}, W'(overflow), W'(0));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        held_result = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        a_in    = '0;
        b_in    = '0;
        carryin = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(64'h0000_0001_0000_FFFF, 64'h1, 1'b1, 1'b0, 64'h0000_0001_0001_0001, 1'b0, 1'b0, 1'b1);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);

        // Abort in the middle of a run.
        start = 1'b1;
        a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WORDS + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", W'(done), W'(0));
            check("abort_no_busy", W'(busy), W'(0));
        end
        held_result = '0;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

`ifdef SUBTRACT_EN
        run_op(64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
`endif

        // Reset while idle clears the published result.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("idle_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
